// File: rtl/zigbee_phase_demod_if.sv
// Phase-sample stream in, chip decisions out, for the Zigbee phase-difference demodulator.
interface zigbee_phase_demod_if #(
  parameter int unsigned W_SIZE   = 6,
  parameter int unsigned ACC_SIZE = 9
);
  logic                       enable;
  logic                       sample_en;
  logic signed [W_SIZE-1:0]   wout;
  logic                       chip_out;
  logic                       chip_valid;
  logic signed [W_SIZE-1:0]   dphi;
  logic signed [ACC_SIZE-1:0] freq_acc;

  modport master (
    output enable, sample_en, wout,
    input  chip_out, chip_valid, dphi, freq_acc
  );

  modport slave (
    input  enable, sample_en, wout,
    output chip_out, chip_valid, dphi, freq_acc
  );
endinterface

// File: rtl/zigbee_phase_demod.sv
// Differentiates CORDIC phase samples, integrates OSR differences per chip and
// slices the sign of the sum into a chip decision.
module zigbee_phase_demod #(
  parameter int unsigned W_SIZE   = 6,
  parameter int unsigned OSR      = 4,
  parameter int unsigned ACC_SIZE = 9
) (
  input logic                 clk,
  input logic                 rst_n,
  zigbee_phase_demod_if.slave demod_io
);

  localparam int unsigned     CntW    = $clog2(OSR);
  localparam logic [CntW-1:0] CntLast = CntW'(OSR - 1);

  if (OSR < 2 || OSR > 16) begin : g_bad_osr
    $error("OSR must lie in 2..16");
  end
  if (ACC_SIZE < W_SIZE + $clog2(OSR) + 1) begin : g_bad_acc
    $error("ACC_SIZE too narrow for W_SIZE and OSR");
  end

  typedef enum logic [1:0] {StIdle, StPrime, StRun} state_e;

  state_e                     state_q, state_d;
  logic signed [W_SIZE-1:0]   prev_w_q, prev_w_d;
  logic signed [ACC_SIZE-1:0] acc_q, acc_d;
  logic [CntW-1:0]            cnt_q, cnt_d;
  logic signed [W_SIZE-1:0]   dphi_q, dphi_d;
  logic signed [ACC_SIZE-1:0] freq_acc_q, freq_acc_d;
  logic                       chip_out_q, chip_out_d;
  logic                       chip_valid_q, chip_valid_d;

  logic signed [W_SIZE-1:0]   diff;
  logic signed [ACC_SIZE-1:0] diff_ext;
  logic signed [ACC_SIZE-1:0] sum;

  // Truncating subtraction gives the modular wrap: +180 deg lands on the most negative code.
  assign diff     = demod_io.wout - prev_w_q;
  assign diff_ext = {{(ACC_SIZE - W_SIZE){diff[W_SIZE-1]}}, diff};
  assign sum      = acc_q + diff_ext;

  always_comb begin
    state_d      = state_q;
    prev_w_d     = prev_w_q;
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    dphi_d       = dphi_q;
    freq_acc_d   = freq_acc_q;
    chip_out_d   = chip_out_q;
    chip_valid_d = 1'b0;

    if (!demod_io.enable) begin
      state_d = StIdle;
      acc_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        StIdle: state_d = StPrime;
        StPrime: begin
          if (demod_io.sample_en) begin
            prev_w_d = demod_io.wout;
            state_d  = StRun;
          end
        end
        StRun: begin
          if (demod_io.sample_en) begin
            prev_w_d = demod_io.wout;
            dphi_d   = diff;
            if (cnt_q == CntLast) begin
              freq_acc_d   = sum;
              acc_d        = '0;
              cnt_d        = '0;
              chip_valid_d = 1'b1;
              // A zero sum carries no information, so the previous decision holds.
              if (sum != '0) begin
                chip_out_d = ~sum[ACC_SIZE-1];
              end
            end else begin
              acc_d = sum;
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      prev_w_q     <= '0;
      acc_q        <= '0;
      cnt_q        <= '0;
      dphi_q       <= '0;
      freq_acc_q   <= '0;
      chip_out_q   <= 1'b0;
      chip_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      prev_w_q     <= prev_w_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      dphi_q       <= dphi_d;
      freq_acc_q   <= freq_acc_d;
      chip_out_q   <= chip_out_d;
      chip_valid_q <= chip_valid_d;
    end
  end

  assign demod_io.chip_out   = chip_out_q;
  assign demod_io.chip_valid = chip_valid_q;
  assign demod_io.dphi       = dphi_q;
  assign demod_io.freq_acc   = freq_acc_q;

endmodule

// File: tb/tb_zigbee_phase_demod.sv
// Directed bench for zigbee_phase_demod: ramps, wrap, hold, abort and async reset.
module tb_zigbee_phase_demod;
  localparam int unsigned W_SIZE   = 6;
  localparam int unsigned OSR      = 4;
  localparam int unsigned ACC_SIZE = 9;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   valid_cnt = 0;
  logic prev_valid = 1'b0;

  zigbee_phase_demod_if #(.W_SIZE(W_SIZE), .ACC_SIZE(ACC_SIZE)) bus ();

  zigbee_phase_demod #(.W_SIZE(W_SIZE), .OSR(OSR), .ACC_SIZE(ACC_SIZE)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .demod_io (bus)
  );

  always #5 clk = ~clk;

  // Pulse counter and back-to-back guard, sampled 2 units after each rising edge.
  always begin
    @(posedge clk);
    #2;
    if (bus.chip_valid === 1'b1) begin
      valid_cnt++;
      checks++;
      if (prev_valid) begin
        errors++;
        $display("FAIL chip_valid_consecutive got 1 on two cycles want single pulse");
      end
    end
    prev_valid = (bus.chip_valid === 1'b1);
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic strobe(input int w);
    @(negedge clk);
    bus.sample_en = 1'b1;
    bus.wout      = w[W_SIZE-1:0];
    @(negedge clk);
    bus.sample_en = 1'b0;
  endtask

  task automatic start();
    @(negedge clk);
    bus.enable = 1'b1;
    @(negedge clk);
  endtask

  task automatic stop();
    @(negedge clk);
    bus.enable = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.enable = 1'b0;
    bus.sample_en = 1'b0;
    bus.wout = '0;
    #3;
    checks++; if (bus.chip_out !== 1'b0) begin errors++; $display("FAIL reset_chip_out got %b want 0", bus.chip_out); end
    checks++; if (bus.chip_valid !== 1'b0) begin errors++; $display("FAIL reset_chip_valid got %b want 0", bus.chip_valid); end
    checks++; if (bus.dphi !== '0) begin errors++; $display("FAIL reset_dphi got %0d want 0", bus.dphi); end
    checks++; if (bus.freq_acc !== '0) begin errors++; $display("FAIL reset_freq_acc got %0d want 0", bus.freq_acc); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_ramp();
    int v0;
    v0 = valid_cnt;
    start();
    for (int i = 0; i < 9; i++) begin
      strobe(2 * i);
      if (i > 0) begin
        checks++; if (int'(bus.dphi) !== 2) begin errors++; $display("FAIL ramp_dphi[%0d] got %0d want 2", i, bus.dphi); end
      end
      if (i == 4 || i == 8) begin
        checks++; if (bus.chip_valid !== 1'b1) begin errors++; $display("FAIL ramp_valid[%0d] got %b want 1", i, bus.chip_valid); end
        checks++; if (bus.chip_out !== 1'b1) begin errors++; $display("FAIL ramp_chip_out[%0d] got %b want 1", i, bus.chip_out); end
        checks++; if (int'(bus.freq_acc) !== 8) begin errors++; $display("FAIL ramp_freq_acc[%0d] got %0d want 8", i, bus.freq_acc); end
      end
    end
    @(negedge clk);
    checks++; if (valid_cnt - v0 !== 2) begin errors++; $display("FAIL ramp_pulses got %0d want 2", valid_cnt - v0); end
  endtask

  task automatic test_down_ramp();
    int v0;
    int vals [5] = '{10, 7, 4, 1, -2};
    stop();
    v0 = valid_cnt;
    start();
    foreach (vals[i]) strobe(vals[i]);
    checks++; if (int'(bus.dphi) !== -3) begin errors++; $display("FAIL down_dphi got %0d want -3", bus.dphi); end
    checks++; if (bus.chip_valid !== 1'b1) begin errors++; $display("FAIL down_valid got %b want 1", bus.chip_valid); end
    checks++; if (bus.chip_out !== 1'b0) begin errors++; $display("FAIL down_chip_out got %b want 0", bus.chip_out); end
    checks++; if (int'(bus.freq_acc) !== -12) begin errors++; $display("FAIL down_freq_acc got %0d want -12", bus.freq_acc); end
    @(negedge clk);
    checks++; if (valid_cnt - v0 !== 1) begin errors++; $display("FAIL down_pulses got %0d want 1", valid_cnt - v0); end
  endtask

  task automatic test_wrap();
    stop();
    start();
    strobe(30);
    strobe(-30);
    checks++; if (int'(bus.dphi) !== 4) begin errors++; $display("FAIL wrap_pos_dphi got %0d want 4", bus.dphi); end
    strobe(-32);
    checks++; if (int'(bus.dphi) !== -2) begin errors++; $display("FAIL wrap_step_dphi got %0d want -2", bus.dphi); end
    strobe(0);
    checks++; if (int'(bus.dphi) !== -32) begin errors++; $display("FAIL wrap_half_dphi got %0d want -32", bus.dphi); end
    strobe(0);
    checks++; if (int'(bus.freq_acc) !== -30) begin errors++; $display("FAIL wrap_freq_acc got %0d want -30", bus.freq_acc); end
    checks++; if (bus.chip_out !== 1'b0) begin errors++; $display("FAIL wrap_chip_out got %b want 0", bus.chip_out); end
  endtask

  task automatic test_constant();
    stop();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    start();
    for (int i = 0; i < 5; i++) strobe(5);
    checks++; if (bus.chip_valid !== 1'b1) begin errors++; $display("FAIL const_valid got %b want 1", bus.chip_valid); end
    checks++; if (int'(bus.freq_acc) !== 0) begin errors++; $display("FAIL const_freq_acc got %0d want 0", bus.freq_acc); end
    checks++; if (bus.chip_out !== 1'b0) begin errors++; $display("FAIL const_chip_out got %b want 0", bus.chip_out); end
    for (int i = 6; i < 10; i++) strobe(i);
    checks++; if (int'(bus.freq_acc) !== 4) begin errors++; $display("FAIL plus_freq_acc got %0d want 4", bus.freq_acc); end
    checks++; if (bus.chip_out !== 1'b1) begin errors++; $display("FAIL plus_chip_out got %b want 1", bus.chip_out); end
    for (int i = 0; i < 4; i++) strobe(9);
    checks++; if (bus.chip_valid !== 1'b1) begin errors++; $display("FAIL hold_valid got %b want 1", bus.chip_valid); end
    checks++; if (int'(bus.freq_acc) !== 0) begin errors++; $display("FAIL hold_freq_acc got %0d want 0", bus.freq_acc); end
    checks++; if (bus.chip_out !== 1'b1) begin errors++; $display("FAIL hold_chip_out got %b want 1", bus.chip_out); end
  endtask

  task automatic test_abort();
    int v0;
    strobe(10);
    strobe(11);
    v0 = valid_cnt;
    // Drop enable together with a strobe: the sample must be ignored.
    @(negedge clk);
    bus.enable    = 1'b0;
    bus.sample_en = 1'b1;
    bus.wout      = 6'sd20;
    @(negedge clk);
    bus.sample_en = 1'b0;
    checks++; if (bus.chip_valid !== 1'b0) begin errors++; $display("FAIL abort_valid got %b want 0", bus.chip_valid); end
    checks++; if (dut.acc_q !== '0) begin errors++; $display("FAIL abort_acc got %0d want 0", dut.acc_q); end
    checks++; if (dut.cnt_q !== '0) begin errors++; $display("FAIL abort_cnt got %0d want 0", dut.cnt_q); end
    checks++; if (int'(bus.dphi) !== 1) begin errors++; $display("FAIL abort_dphi got %0d want 1", bus.dphi); end
    checks++; if (int'(bus.freq_acc) !== 0) begin errors++; $display("FAIL abort_freq_acc got %0d want 0", bus.freq_acc); end
    bus.enable = 1'b1;
    @(negedge clk);
    strobe(10);
    checks++; if (int'(bus.dphi) !== 1) begin errors++; $display("FAIL prime_dphi got %0d want 1", bus.dphi); end
    for (int i = 9; i > 6; i--) strobe(i);
    checks++; if (valid_cnt !== v0) begin errors++; $display("FAIL reenable_early got %0d pulses want 0", valid_cnt - v0); end
    strobe(6);
    checks++; if (bus.chip_valid !== 1'b1) begin errors++; $display("FAIL reenable_valid got %b want 1", bus.chip_valid); end
    checks++; if (int'(bus.freq_acc) !== -4) begin errors++; $display("FAIL reenable_freq_acc got %0d want -4", bus.freq_acc); end
    checks++; if (bus.chip_out !== 1'b0) begin errors++; $display("FAIL reenable_chip_out got %b want 0", bus.chip_out); end
  endtask

  task automatic test_async_reset();
    int v0;
    strobe(8);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.dphi !== '0) begin errors++; $display("FAIL areset_dphi got %0d want 0", bus.dphi); end
    checks++; if (bus.freq_acc !== '0) begin errors++; $display("FAIL areset_freq_acc got %0d want 0", bus.freq_acc); end
    checks++; if (bus.chip_out !== 1'b0 || bus.chip_valid !== 1'b0) begin
      errors++; $display("FAIL areset_chip got %b%b want 00", bus.chip_out, bus.chip_valid);
    end
    checks++; if (dut.acc_q !== '0 || dut.cnt_q !== '0) begin
      errors++; $display("FAIL areset_acc_cnt got %0d/%0d want 0/0", dut.acc_q, dut.cnt_q);
    end
    @(negedge clk);
    rst_n = 1'b1;
    v0 = valid_cnt;
    for (int i = 0; i < 4; i++) strobe(i);
    checks++; if (valid_cnt !== v0) begin errors++; $display("FAIL areset_early got %0d pulses want 0", valid_cnt - v0); end
    strobe(4);
    checks++; if (int'(bus.freq_acc) !== 4) begin errors++; $display("FAIL areset_freq_acc2 got %0d want 4", bus.freq_acc); end
    checks++; if (bus.chip_out !== 1'b1) begin errors++; $display("FAIL areset_chip_out2 got %b want 1", bus.chip_out); end
    @(negedge clk);
    checks++; if (valid_cnt - v0 !== 1) begin errors++; $display("FAIL areset_pulses got %0d want 1", valid_cnt - v0); end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_down_ramp();
    test_wrap();
    test_constant();
    test_abort();
    test_async_reset();
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/zigbee_phase_demod.md
ZIGBEE_PHASE_DEMOD -- requirements
Module: zigbee_phase_demod

Interface
REQ-001 Parameter W_SIZE, default 6: width of the signed phase input, 5.625 deg/LSB, full circle = 2^W_SIZE LSB.
REQ-002 Parameter OSR, default 4: phase samples per chip, legal range 2..16.
REQ-003 Parameter ACC_SIZE, default 9: signed accumulator width. It SHALL be at least W_SIZE+ceil(log2(OSR))+1, checked at elaboration.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous and active-low.
REQ-006 enable  input  1  demodulator run; low forces IDLE.
REQ-007 sample_en  input  1  Wout valid this cycle (one-cycle strobe).
REQ-008 Wout  input  W_SIZE  signed phase from the CORDIC stage.
REQ-009 chip_out  output  1  demodulated chip decision, registered.
REQ-010 chip_valid  output  1  one-cycle pulse, chip_out/freq_acc updated.
REQ-011 dphi  output  W_SIZE  signed last phase difference, registered.
REQ-012 freq_acc  output  ACC_SIZE  signed accumulated phase difference of the last completed chip.

Function
REQ-013 The block SHALL implement states IDLE, PRIME and RUN.
REQ-014 IDLE: enable=1 -> PRIME; no sample is consumed on the transition cycle.
REQ-015 PRIME: on sample_en=1, store Wout in prev_w and go to RUN; no difference is produced.
REQ-016 RUN: on sample_en=1, dphi <= (Wout - prev_w) mod 2^W_SIZE as signed, and prev_w <= Wout.
REQ-017 Phase wrap SHALL be modular: a difference of +180 deg maps to -2^(W_SIZE-1); no other correction.
REQ-018 RUN: each accepted sample SHALL add sign-extended dphi to acc and increment sample counter cnt (0..OSR-1).
REQ-019 On the sample where cnt=OSR-1 (chip boundary), the block SHALL:
- set freq_acc to the final sum (acc plus the current dphi);
- clear acc and cnt;
- pulse chip_valid in the next cycle, aligned with the updated chip_out/freq_acc.
REQ-020 Decision: sum>0 -> chip_out=1; sum<0 -> chip_out=0; sum=0 -> chip_out holds its previous value.
REQ-021 Latency SHALL be one clock from the boundary sample_en edge to chip_valid.
REQ-022 Cycles with sample_en=0 SHALL leave prev_w, acc, cnt, dphi unchanged; chip_valid=0.
REQ-023 enable=0 in any state SHALL force IDLE next cycle and clear acc and cnt.
REQ-024 On a cycle with enable=0, a partial chip SHALL be discarded with no chip_valid; chip_out, freq_acc and dphi hold.
REQ-025 If enable=0 and sample_en=1 occur in the same cycle, enable SHALL take priority and the sample is ignored.
REQ-026 Re-enabling SHALL pass through PRIME again, with the first post-enable sample as the reference only.
REQ-027 chip_valid SHALL never be asserted on two consecutive cycles.

Reset
REQ-028 rst_n=0 SHALL asynchronously clear the state to IDLE and zero prev_w, acc, cnt, dphi, freq_acc, chip_out and chip_valid.
REQ-029 After rst_n rises, operation SHALL begin at the first rising edge with enable=1 (IDLE->PRIME).
REQ-030 Reset asserted mid-chip SHALL discard the partial chip with no chip_valid.

Verification
REQ-031 Ramp: enable=1, Wout=0,2,4,...,16 on 9 strobes (OSR=4) -> dphi=2 each, two chip_valid pulses, chip_out=1, freq_acc=8.
REQ-032 Down-ramp: Wout=10,7,4,1,-2 -> one chip_valid, chip_out=0, freq_acc=-12.
REQ-033 Wrap: Wout=30 then -30 -> dphi=+4 (not -60); Wout=-32 then 0 -> dphi=-32.
REQ-034 Constant: Wout=5 for 5 strobes after reset -> freq_acc=0, chip_out held at 0. Then a +1 chip followed by a constant chip -> second chip_out=1 (hold).
REQ-035 Abort: enable=0 after 2 RUN samples -> no chip_valid, acc=0. Re-enable: the first strobe is PRIME only, and the next chip completes after OSR further strobes.
REQ-036 Async reset mid-chip at a non-clock-edge time -> all outputs 0 immediately, state IDLE, no chip_valid afterwards until a full chip is received.
